sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_pkg.sv | 15 +
 rtl/sram_port_arbiter.sv | 99 +++++++++
 tb/tb_sram_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared CPU package: SRAM port owner encoding and arbiter defaults.
package sram_port_arbiter_pkg;

    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned DATA_W             = 32;
    localparam int unsigned CNT_W              = 4;
    localparam int unsigned STARVE_MAX_DEFAULT = 4;

    // Which requester owns the response currently in flight
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

endpackage

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch (IF) and data (MEM).
// MEM has priority unless IF has waited STARVE_MAX MEM grants in a row.
// Responses return exactly one cycle after acceptance.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    input  logic              if_flush,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    logic [CNT_W-1:0] starve_cnt;
    logic             starving_c;
    logic             grant_if_c;
    logic             grant_mem_c;

    logic             rsp_valid;
    owner_e           rsp_owner;
    logic             rsp_kill;
    logic             rsp_we;

    // Grant decision: MEM first, IF when idle MEM or when IF is starving
    always_comb begin
        starving_c  = if_req && (starve_cnt == CNT_W'(STARVE_MAX));
        grant_mem_c = !reset && mem_req && !starving_c;
        grant_if_c  = !reset && if_req && !grant_mem_c;
    end

    // SRAM request side, driven straight from the grant
    always_comb begin
        if_ready   = grant_if_c;
        mem_ready  = grant_mem_c;
        sram_en    = grant_if_c || grant_mem_c;
        sram_we    = grant_mem_c && mem_we;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_mem_c) begin
            sram_addr  = mem_addr;
            sram_wdata = mem_wdata;
        end else if (grant_if_c) begin
            sram_addr  = if_addr;
        end
    end

    // Count consecutive MEM wins while IF waits; any IF win or IF idle clears
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req || grant_if_c) begin
            starve_cnt <= '0;
        end else if (grant_mem_c && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Track the single access in flight; a fresh grant always starts un-killed,
    // a flush in the response cycle suppresses it combinationally below
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_owner <= OWN_IF;
            rsp_kill  <= 1'b0;
            rsp_we    <= 1'b0;
        end else begin
            rsp_valid <= sram_en;
            rsp_owner <= grant_mem_c ? OWN_MEM : OWN_IF;
            rsp_kill  <= 1'b0;
            rsp_we    <= sram_we;
        end
    end

    // Response steering; data forced to zero whenever its valid is low
    always_comb begin
        if_rvalid  = !reset && rsp_valid && (rsp_owner == OWN_IF) && !rsp_kill && !if_flush;
        mem_rvalid = !reset && rsp_valid && (rsp_owner == OWN_MEM);
        if_rdata   = if_rvalid ? sram_rdata : '0;
        mem_rdata  = (mem_rvalid && !rsp_we) ? sram_rdata : '0;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a scoreboard of expected responses.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic        if_ready, if_rvalid, mem_ready, mem_rvalid;
    logic [31:0] if_rdata, mem_rdata;
    logic        sram_en, sram_we;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = 32'h0;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        int          due;
        logic        if_v;
        logic [31:0] if_d;
        logic        mem_v;
        logic [31:0] mem_d;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;

    logic [31:0] sram_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];

    localparam logic [31:0] IF_A  = 32'h1c000000;
    localparam logic [31:0] IF_B  = 32'h1c000004;
    localparam logic [31:0] MEM_A = 32'h1c008000;
    localparam logic [31:0] MEM_B = 32'h00000020;

    sram_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_flush(if_flush), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_sram(input logic [31:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Behavioural SRAM: read data valid the cycle after an enabled read
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) sram_mem[sram_addr] = sram_wdata;
            else         sram_rdata <= rd_sram(sram_addr);
        end
    end

    // Scoreboard: every cycle compare responses against the entry due now (or none)
    always @(negedge clk) begin
        e_cur = '{due: 0, if_v: 1'b0, if_d: 32'h0, mem_v: 1'b0, mem_d: 32'h0};
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            n_total++;
            $display("FAIL stale_entry: got due %0d at cycle %0d", exp_q[0].due, cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) e_cur = exp_q.pop_front();
        n_total++;
        if (if_rvalid !== e_cur.if_v) $display("FAIL if_rvalid@%0d: got %b want %b", cyc, if_rvalid, e_cur.if_v);
        else n_pass++;
        n_total++;
        if (if_rdata !== e_cur.if_d) $display("FAIL if_rdata@%0d: got %h want %h", cyc, if_rdata, e_cur.if_d);
        else n_pass++;
        n_total++;
        if (mem_rvalid !== e_cur.mem_v) $display("FAIL mem_rvalid@%0d: got %b want %b", cyc, mem_rvalid, e_cur.mem_v);
        else n_pass++;
        n_total++;
        if (mem_rdata !== e_cur.mem_d) $display("FAIL mem_rdata@%0d: got %h want %h", cyc, mem_rdata, e_cur.mem_d);
        else n_pass++;
    end

    task automatic issue(input logic ir, input logic [31:0] ia, input logic fl,
                         input logic mr, input logic mw, input logic [31:0] ma,
                         input logic [31:0] mwd);
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia; if_flush = fl;
        mem_req = mr; mem_we = mw; mem_addr = ma; mem_wdata = mwd;
        @(negedge clk);
    endtask

    task automatic idle();
        issue(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic push_exp(input logic iv, input logic [31:0] id,
                            input logic mv, input logic [31:0] md);
        exp_t e;
        e.due = cyc + 1; e.if_v = iv; e.if_d = id; e.mem_v = mv; e.mem_d = md;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, IF_A, 1'b0, 1'b1, 1'b1, MEM_A, 32'hffffffff);
            n_total++;
            if ({if_ready, mem_ready, sram_en, sram_we} !== 4'b0000)
                $display("FAIL reset_strobes: got %b want 0000", {if_ready, mem_ready, sram_en, sram_we});
            else n_pass++;
            n_total++;
            if ({sram_addr, sram_wdata} !== 64'h0)
                $display("FAIL reset_bus: got %h want 0", {sram_addr, sram_wdata});
            else n_pass++;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_if_fetch();
        issue(1'b1, IF_A, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_total++;
        if ({if_ready, mem_ready, sram_en, sram_we} !== 4'b1010)
            $display("FAIL fetch_strobes: got %b want 1010", {if_ready, mem_ready, sram_en, sram_we});
        else n_pass++;
        n_total++;
        if (sram_addr !== IF_A) $display("FAIL fetch_addr: got %h want %h", sram_addr, IF_A);
        else n_pass++;
        push_exp(1'b1, rd_ref(IF_A), 1'b0, 32'h0);
        idle();
        n_total++;
        if ({sram_en, sram_addr} !== 33'h0) $display("FAIL idle_bus: got %h want 0", {sram_en, sram_addr});
        else n_pass++;
    endtask

    task automatic test_priority();
        issue(1'b1, IF_A, 1'b0, 1'b1, 1'b0, MEM_A, 32'h0);
        n_total++;
        if ({if_ready, mem_ready} !== 2'b01) $display("FAIL prio_ready: got %b want 01", {if_ready, mem_ready});
        else n_pass++;
        n_total++;
        if (sram_addr !== MEM_A) $display("FAIL prio_addr: got %h want %h", sram_addr, MEM_A);
        else n_pass++;
        push_exp(1'b0, 32'h0, 1'b1, rd_ref(MEM_A));
        idle();
    endtask

    task automatic test_starvation();
        logic pat [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            issue(1'b1, IF_A, 1'b0, 1'b1, 1'b0, MEM_B, 32'h0);
            n_total++;
            if ({mem_ready, if_ready} !== {pat[i], !pat[i]})
                $display("FAIL starve_grant[%0d]: got mem/if %b%b want %b%b", i, mem_ready, if_ready, pat[i], !pat[i]);
            else n_pass++;
            if (pat[i]) push_exp(1'b0, 32'h0, 1'b1, rd_ref(MEM_B));
            else        push_exp(1'b1, rd_ref(IF_A), 1'b0, 32'h0);
        end
        idle();
    endtask

    task automatic test_store();
        issue(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 32'hdeadbeef);
        n_total++;
        if ({mem_ready, sram_en, sram_we} !== 3'b111) $display("FAIL store_strobes: got %b want 111", {mem_ready, sram_en, sram_we});
        else n_pass++;
        n_total++;
        if ({sram_addr, sram_wdata} !== {32'h10, 32'hdeadbeef})
            $display("FAIL store_bus: got %h want %h", {sram_addr, sram_wdata}, {32'h10, 32'hdeadbeef});
        else n_pass++;
        ref_mem[32'h10] = 32'hdeadbeef;
        push_exp(1'b0, 32'h0, 1'b1, 32'h0);
        // back-to-back load of the stored word
        issue(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        n_total++;
        if (sram_we !== 1'b0) $display("FAIL load_we: got %b want 0", sram_we);
        else n_pass++;
        push_exp(1'b0, 32'h0, 1'b1, rd_ref(32'h10));
        // fetch while stale write data sits on mem_wdata
        issue(1'b1, IF_B, 1'b0, 1'b0, 1'b1, 32'h44, 32'hffffffff);
        n_total++;
        if ({sram_we, sram_wdata} !== 33'h0) $display("FAIL fetch_wdata: got %h want 0", {sram_we, sram_wdata});
        else n_pass++;
        push_exp(1'b1, rd_ref(IF_B), 1'b0, 32'h0);
        idle();
    endtask

    task automatic test_flush();
        // first fetch is killed by the flush in its response cycle
        issue(1'b1, IF_A, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push_exp(1'b0, 32'h0, 1'b0, 32'h0);
        // new fetch granted in the flush cycle returns normally
        issue(1'b1, IF_B, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        n_total++;
        if (if_ready !== 1'b1) $display("FAIL flush_new_grant: got %b want 1", if_ready);
        else n_pass++;
        push_exp(1'b1, rd_ref(IF_B), 1'b0, 32'h0);
        // flush does not touch a MEM response
        issue(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, MEM_B, 32'h0);
        push_exp(1'b0, 32'h0, 1'b1, rd_ref(MEM_B));
        issue(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
    endtask

    task automatic test_reset_mid();
        // fetch issued right before reset is dropped
        issue(1'b1, IF_A, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1; if_req = 1'b0;
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        // build up starvation count, then reset with both requests held
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, IF_A, 1'b0, 1'b1, 1'b0, MEM_B, 32'h0);
            if (i < 2) push_exp(1'b0, 32'h0, 1'b1, rd_ref(MEM_B));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({if_ready, mem_ready, sram_en} !== 3'b000) $display("FAIL midreset_grant: got %b want 000", {if_ready, mem_ready, sram_en});
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (mem_ready !== 1'b1) $display("FAIL postreset_grant0: got %b want 1", mem_ready);
        else n_pass++;
        push_exp(1'b0, 32'h0, 1'b1, rd_ref(MEM_B));
        for (int i = 1; i < 5; i++) begin
            issue(1'b1, IF_A, 1'b0, 1'b1, 1'b0, MEM_B, 32'h0);
            n_total++;
            if ({mem_ready, if_ready} !== ((i < 4) ? 2'b10 : 2'b01))
                $display("FAIL postreset_grant%0d: got mem/if %b%b want %b", i, mem_ready, if_ready, (i < 4) ? 2'b10 : 2'b01);
            else n_pass++;
            if (i < 4) push_exp(1'b0, 32'h0, 1'b1, rd_ref(MEM_B));
            else       push_exp(1'b1, rd_ref(IF_A), 1'b0, 32'h0);
        end
        idle();
    endtask

    initial begin
        sram_mem[IF_A]  = 32'h02800421; ref_mem[IF_A]  = 32'h02800421;
        sram_mem[IF_B]  = 32'h00000013; ref_mem[IF_B]  = 32'h00000013;
        sram_mem[MEM_A] = 32'h11223344; ref_mem[MEM_A] = 32'h11223344;
        sram_mem[MEM_B] = 32'h0badf00d; ref_mem[MEM_B] = 32'h0badf00d;
        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;

        test_reset();
        test_if_fetch();
        test_priority();
        test_starvation();
        test_store();
        test_flush();
        test_reset_mid();

        repeat (3) idle();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
